// File: rtl/ram_fifo_ctrl_ram.sv
// Purpose: simple dual-port RAM, one write port and one registered read port on a single clock.
// Latency: write lands at the clock edge; read data appears one edge after r_addr is sampled.
// Backpressure: none; the caller gates we and holds r_addr when the output must stay stable.
module ram_fifo_ctrl_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [WIDTH-1:0]      w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [WIDTH-1:0]      r_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage has no reset; the controller's pointers keep stale words out of view.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
    r_data <= mem[r_addr];
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Purpose: single-clock FIFO controller sequencing a dual-port RAM (pointers, count, flags, output hold).
// Latency: word written at edge T is readable after T; read accepted at edge T shows dout_valid after T+1.
// Backpressure: writes while full are dropped (overflow pulse), reads while empty are dropped (underflow pulse).
module ram_fifo_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  // The pointers rely on natural wrap, so the RAM must be exactly a power of two deep.
  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("ram_fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  rd_pend;
  logic [WIDTH-1:0]      ram_q;

  // Acceptance uses only the registered flags, so a simultaneous read never frees room for a write in the same cycle.
  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // r_addr sits on rd_ptr permanently; it only moves when a read is accepted, keeping the RAM output stable otherwise.
  ram_fifo_ctrl_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (wr_acc),
    .w_addr (wr_ptr),
    .w_data (din),
    .r_addr (rd_ptr),
    .r_data (ram_q)
  );

  // Pointers, occupancy and flags; flags come from the next count so they are glitch-free registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Read pipeline: rd_pend marks RAM output valid next edge, where it is captured into the held dout register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend    <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      rd_pend    <= rd_acc;
      dout_valid <= rd_pend;
      if (rd_pend) begin
        dout <= ram_q;
      end
    end
  end

  // Dropped-request pulses, registered one cycle after the offending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Purpose: directed self-checking bench for ram_fifo_ctrl.
// Latency: inputs driven on falling edges, outputs sampled on the following falling edge.
// Backpressure: exercises full/empty drop cases, wrap-around streaming and reset during a pending read.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;
  logic [7:0] got [$];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.WIDTH(8), .ADDR_WIDTH(3), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // Collect every word the consumer would see.
  always @(negedge clk) begin
    if (!rst && dout_valid) got.push_back(dout);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // One clock of stimulus; returns on the falling edge after the rising edge that consumed it.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    int bad;
    @(negedge clk);
    @(negedge clk);
    // Reset state
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_dout", dout, 0);
    check("rst_dv", dout_valid, 0);
    rst = 1'b0;

    // Idle: no pulses of any kind
    for (int i = 0; i < 10; i++) begin
      cyc(0, 8'h00, 0);
      pulses += int'(dout_valid) + int'(overflow) + int'(underflow);
    end
    check("idle_pulses", pulses, 0);
    check("idle_empty", empty, 1);

    // Fill 8 words
    for (int i = 0; i < 8; i++) cyc(1, 8'h11 + 8'(i), 0);
    check("fill_count", count, 8);
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);

    // Drain 8 with latency check on the first
    got.delete();
    cyc(0, 8'h00, 1);
    check("rd_lat_t0", dout_valid, 0);
    cyc(0, 8'h00, 1);
    check("rd_lat_t1_dv", dout_valid, 1);
    check("rd_lat_t1_dout", dout, 8'h11);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    check("drain_n", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check($sformatf("drain_%0d", i), got[i], 8'h11 + 8'(i));
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);

    // Overflow: full with both requests
    for (int i = 0; i < 8; i++) cyc(1, 8'h21 + 8'(i), 0);
    got.delete();
    cyc(1, 8'hAA, 1);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 7);
    check("ovf_full", full, 0);
    cyc(0, 8'h00, 0);
    check("ovf_once", overflow, 0);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    check("ovf_n", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check($sformatf("ovf_word_%0d", i), got[i], 8'h21 + 8'(i));
    check("ovf_empty", empty, 1);

    // Underflow: empty with both requests
    got.delete();
    cyc(1, 8'h5C, 1);
    check("unf_pulse", underflow, 1);
    check("unf_count", count, 1);
    check("unf_empty", empty, 0);
    cyc(0, 8'h00, 0);
    check("unf_once", underflow, 0);
    check("unf_no_dv", got.size(), 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    check("unf_n", got.size(), 1);
    if (got.size() > 0) check("unf_word", got[0], 8'h5C);

    // Wrap-around streaming at occupancy 3
    got.delete();
    for (int i = 0; i < 3; i++) cyc(1, 8'h30 + 8'(i), 0);
    check("wrap_pre", count, 3);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'h33 + 8'(i), 1);
      if (count !== 4'd3) bad++;
    end
    check("wrap_cnt", bad, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    check("wrap_n", got.size(), 23);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 8'h30 + 8'(i)) bad++;
    check("wrap_order", bad, 0);
    check("wrap_empty", empty, 1);

    // Reset while a read is in flight
    for (int i = 0; i < 4; i++) cyc(1, 8'h40 + 8'(i), 0);
    check("mid_count", count, 4);
    got.delete();
    cyc(0, 8'h00, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_dout", dout, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0);
    check("mid_no_dv", got.size(), 0);
    check("mid_count_after", count, 0);
    check("mid_empty_after", empty, 1);
    check("mid_dout_after", dout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that sequences a dual-port RAM instance as single-clock first-in/first-out storage. It owns the write/read pointers, occupancy count and full/empty flags. It gates the RAM write enable and latches RAM read data into a held output register. It sits between a producer and a consumer that share one clock domain and need elastic buffering.

## Interface
- WIDTH, 8, data word width in bits
- ADDR_WIDTH, 3, RAM address width
- DEPTH, 8, number of RAM words; must equal 2**ADDR_WIDTH (elaboration-time check)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  producer write request
- din  input  WIDTH  write data, sampled with wr_en
- rd_en  input  1  consumer read request
- dout  output  WIDTH  read data, held until next read completes
- dout_valid  output  1  one-cycle pulse: dout carries a newly read word
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write requested while full, word dropped
- underflow  output  1  one-cycle pulse: read requested while empty, request dropped

## Operation
- Reset (async assert, any cycle, mid-operation included) clears:
  - wr_ptr, rd_ptr and count to 0
  - dout to 0
  - dout_valid, overflow, underflow and full to 0
  - empty to 1
- RAM contents are not cleared. Stale words are never visible because the pointers reset.
- The write is accepted (wr_acc) when wr_en && !full. It drives RAM we=1, w_addr=wr_ptr, din=din. wr_ptr increments.
- The read is accepted (rd_acc) when rd_en && !empty. It drives RAM r_addr=rd_ptr. rd_ptr increments.
- full and empty are evaluated from registered state at the start of the cycle, never combinationally from the current request.
- Count update:
  - wr_acc only: count +1
  - rd_acc only: count −1
  - both or neither: count unchanged
- Simultaneous requests:
  - Full with both wr_en and rd_en: the read is accepted, the write is dropped and overflow pulses.
  - Empty with both wr_en and rd_en: the write is accepted, the read is dropped and underflow pulses.
- Pointers are ADDR_WIDTH bits and wrap DEPTH−1 → 0 by natural overflow.
- Read and write addresses never collide in an accepted cycle. Equal pointers imply full or empty, and one side is then blocked.
- r_addr is held at rd_ptr whenever no read is accepted, so the RAM output stays stable.
- full/empty/count are registered outputs derived from the next count, with no decode glitches.

## Timing
- Write: accepted at edge T, the word is in RAM after edge T. empty deasserts and count increments in the cycle after T.
- Read latency is 2 cycles:
  - rd_acc at edge T: the RAM samples r_addr.
  - Edge T+1: RAM output is valid, and the controller latches it into dout with the d1 stage flag set.
  - After edge T+1: dout is updated and dout_valid=1 for one cycle.
- Back-to-back reads give one dout_valid per cycle, in order.
- overflow and underflow are registered one cycle after the offending request.
- A reset asserted between rd_acc and dout_valid cancels the pending read: no dout_valid after reset release.
- First accepted request is possible in the first clk edge after rst deasserts.

## Structure
- Shared package: none needed. Parameters stay local. The width of count is derived as ADDR_WIDTH+1.
- Natural sub-module: one dualPortRam instance (WIDTH, ADDR_WIDTH, DEPTH passed through).
- Controller logic: pointers, count, flag registers, the read-pending pipeline bit and the dout holding register.

## Test plan
- Reset then idle → empty=1, full=0, count=0, dout=0; no pulses for 10 cycles.
- Write 0x11..0x18 (8 words) then read 8 → count reaches 8 and full=1. dout_valid pulses 8 times with 0x11..0x18 in order, each 2 cycles after its rd_acc. Ends with empty=1.
- Full FIFO, wr_en=rd_en=1 with din=0xAA for 1 cycle → read accepted and write dropped. overflow pulses and count=7. 0xAA never appears on dout.
- Empty FIFO, wr_en=rd_en=1 with din=0x5C → write accepted, underflow pulses, count=1. A subsequent read returns 0x5C.
- Wrap-around: run 20 cycles of streaming with wr_en=rd_en=1 at count 3, then drain → pointers wrap at least twice, count stays 3, output sequence is exact and in order.
- Assert rst one cycle after rd_acc with count=4 → no dout_valid follows. After release, count=0, empty=1 and dout=0.
